// File: rtl/hs32_pkg.sv
// Shared definitions for the hs32 core: memory arbiter state encoding and
// memory direction encoding.
package hs32_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_F = 2'd1,
        ARB_BUSY_E = 2'd2
    } arb_state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/hs32_mem_arbiter.sv
// Single-port memory arbiter between the fetch stage (read-only) and the execute
// stage (load/store); one transaction at a time, refused requests get a stall pulse.
module hs32_mem_arbiter
    import hs32_pkg::*;
#(
    parameter logic EXEC_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr_f,
    input  logic        stb_f,
    output logic [31:0] dtr_f,
    output logic        ack_f,
    output logic        stl_f,
    input  logic        flush_f,
    input  logic [31:0] addr_e,
    input  logic [31:0] dtw_e,
    input  logic        rw_e,
    input  logic        stb_e,
    output logic [31:0] dtr_e,
    output logic        ack_e,
    output logic        stl_e,
    output logic [31:0] addr_m,
    output logic [31:0] dtw_m,
    output logic        rw_m,
    output logic        stb_m,
    input  logic [31:0] dtr_m,
    input  logic        ack_m
);

    arb_state_t  state_r;
    arb_state_t  state_s;
    logic        drop_r;
    logic        drop_s;
    logic        req_f_s;
    logic [31:0] addr_m_s;
    logic [31:0] dtw_m_s;
    logic        rw_m_s;
    logic        stb_m_s;
    logic [31:0] dtr_f_s;
    logic [31:0] dtr_e_s;
    logic        ack_f_s;
    logic        ack_e_s;
    logic        stl_f_s;
    logic        stl_e_s;

    function automatic logic grant_exec(input logic req_f, input logic req_e);
        return req_e & (~req_f | EXEC_PRIORITY);
    endfunction

    // Next-state and next-output logic; a strobe alongside its own completing ack
    // is not refused so that ack and stall never coincide for one client.
    always_comb begin
        state_s  = state_r;
        drop_s   = drop_r;
        addr_m_s = addr_m;
        dtw_m_s  = dtw_m;
        rw_m_s   = rw_m;
        stb_m_s  = 1'b0;
        dtr_f_s  = dtr_f;
        dtr_e_s  = dtr_e;
        ack_f_s  = 1'b0;
        ack_e_s  = 1'b0;
        stl_f_s  = 1'b0;
        stl_e_s  = 1'b0;
        req_f_s  = stb_f & ~flush_f;
        case (state_r)
            ARB_IDLE: begin
                if (req_f_s | stb_e) begin
                    stb_m_s = 1'b1;
                    if (grant_exec(req_f_s, stb_e)) begin
                        state_s  = ARB_BUSY_E;
                        addr_m_s = addr_e;
                        dtw_m_s  = dtw_e;
                        rw_m_s   = rw_e ? RW_WRITE : RW_READ;
                        stl_f_s  = req_f_s;
                    end else begin
                        state_s  = ARB_BUSY_F;
                        addr_m_s = addr_f;
                        dtw_m_s  = 32'h0000_0000;
                        rw_m_s   = RW_READ;
                        stl_e_s  = stb_e;
                    end
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_BUSY_F: begin
                stl_e_s = stb_e;
                if (ack_m) begin
                    state_s = ARB_IDLE;
                    drop_s  = 1'b0;
                    if (drop_r | flush_f) begin
                        stl_f_s = req_f_s;
                    end else begin
                        ack_f_s = 1'b1;
                        dtr_f_s = dtr_m;
                    end
                end else begin
                    drop_s  = drop_r | flush_f;
                    stl_f_s = req_f_s;
                end
            end
            ARB_BUSY_E: begin
                stl_f_s = req_f_s;
                if (ack_m) begin
                    state_s = ARB_IDLE;
                    ack_e_s = 1'b1;
                    dtr_e_s = dtr_m;
                end else begin
                    stl_e_s = stb_e;
                end
            end
            default: begin
                state_s = ARB_IDLE;
                drop_s  = 1'b0;
            end
        endcase
    end

    // State, drop flag and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ARB_IDLE;
            drop_r  <= 1'b0;
            addr_m  <= 32'h0000_0000;
            dtw_m   <= 32'h0000_0000;
            rw_m    <= 1'b0;
            stb_m   <= 1'b0;
            dtr_f   <= 32'h0000_0000;
            dtr_e   <= 32'h0000_0000;
            ack_f   <= 1'b0;
            ack_e   <= 1'b0;
            stl_f   <= 1'b0;
            stl_e   <= 1'b0;
        end else begin
            state_r <= state_s;
            drop_r  <= drop_s;
            addr_m  <= addr_m_s;
            dtw_m   <= dtw_m_s;
            rw_m    <= rw_m_s;
            stb_m   <= stb_m_s;
            dtr_f   <= dtr_f_s;
            dtr_e   <= dtr_e_s;
            ack_f   <= ack_f_s;
            ack_e   <= ack_e_s;
            stl_f   <= stl_f_s;
            stl_e   <= stl_e_s;
        end
    end

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// Self-checking bench for hs32_mem_arbiter: directed scenarios then randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_hs32_mem_arbiter;

    localparam logic EXEC_PRIORITY = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_f, addr_e, dtw_e, dtr_m;
    logic        stb_f, flush_f, rw_e, stb_e, ack_m;
    logic [31:0] dtr_f, dtr_e, addr_m, dtw_m;
    logic        ack_f, stl_f, ack_e, stl_e, rw_m, stb_m;

    always #5 clk = ~clk;

    hs32_mem_arbiter #(.EXEC_PRIORITY(EXEC_PRIORITY)) dut (
        .clk(clk), .reset(reset),
        .addr_f(addr_f), .stb_f(stb_f), .dtr_f(dtr_f), .ack_f(ack_f), .stl_f(stl_f),
        .flush_f(flush_f),
        .addr_e(addr_e), .dtw_e(dtw_e), .rw_e(rw_e), .stb_e(stb_e),
        .dtr_e(dtr_e), .ack_e(ack_e), .stl_e(stl_e),
        .addr_m(addr_m), .dtw_m(dtw_m), .rw_m(rw_m), .stb_m(stb_m),
        .dtr_m(dtr_m), .ack_m(ack_m)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: who owns the memory port (0 none, 1 fetch, 2 execute)
    int          owner = 0;
    bit          dropped = 1'b0;
    bit          dtr_e_known = 1'b1;
    logic [31:0] x_addr_m = 32'h0, x_dtw_m = 32'h0, x_dtr_f = 32'h0, x_dtr_e = 32'h0;
    logic        x_rw_m = 1'b0, x_stb_m = 1'b0, x_ack_f = 1'b0, x_stl_f = 1'b0;
    logic        x_ack_e = 1'b0, x_stl_e = 1'b0;

    bit          auto_mem = 1'b0;
    int          mem_left = -1;
    logic [31:0] held_dtr_f;
    logic [31:0] words [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic fr;
        fr = stb_f && !flush_f;
        if (!reset) begin
            owner = 0; dropped = 1'b0; dtr_e_known = 1'b1;
            x_addr_m = 32'h0; x_dtw_m = 32'h0; x_dtr_f = 32'h0; x_dtr_e = 32'h0;
            x_rw_m = 1'b0; x_stb_m = 1'b0; x_ack_f = 1'b0; x_stl_f = 1'b0;
            x_ack_e = 1'b0; x_stl_e = 1'b0;
        end else begin
            x_stb_m = 1'b0; x_ack_f = 1'b0; x_ack_e = 1'b0; x_stl_f = 1'b0; x_stl_e = 1'b0;
            if (owner == 0) begin
                if (fr || stb_e) begin
                    x_stb_m = 1'b1;
                    if (stb_e && (EXEC_PRIORITY || !fr)) begin
                        owner = 2; x_addr_m = addr_e; x_dtw_m = dtw_e; x_rw_m = rw_e;
                        x_stl_f = fr;
                    end else begin
                        owner = 1; x_addr_m = addr_f; x_dtw_m = 32'h0; x_rw_m = 1'b0;
                        x_stl_e = stb_e;
                    end
                end
            end else begin
                if (owner == 1) begin
                    if (flush_f) dropped = 1'b1;
                    if (ack_m) begin
                        if (!dropped) begin x_ack_f = 1'b1; x_dtr_f = dtr_m; end
                        dropped = 1'b0;
                        owner = 0;
                    end
                end else if (ack_m) begin
                    x_ack_e = 1'b1;
                    x_dtr_e = dtr_m;
                    dtr_e_known = (x_rw_m == 1'b0);
                    owner = 0;
                end
                x_stl_f = fr && !x_ack_f;
                x_stl_e = stb_e && !x_ack_e;
            end
        end
    endtask

    task automatic cycle();
        if (auto_mem) begin
            ack_m = 1'b0;
            dtr_m = $urandom;
            if (mem_left == 0) ack_m = 1'b1;
            if (mem_left >= 0) mem_left--;
            if (mem_left < 0 && owner == 0 && ($urandom % 6) == 0) ack_m = 1'b1;
        end
        model_edge();
        @(posedge clk);
        #1;
        chk("addr_m", addr_m, x_addr_m);
        chk("dtw_m", dtw_m, x_dtw_m);
        chk("rw_m", {31'h0, rw_m}, {31'h0, x_rw_m});
        chk("stb_m", {31'h0, stb_m}, {31'h0, x_stb_m});
        chk("ack_f", {31'h0, ack_f}, {31'h0, x_ack_f});
        chk("stl_f", {31'h0, stl_f}, {31'h0, x_stl_f});
        chk("dtr_f", dtr_f, x_dtr_f);
        chk("ack_e", {31'h0, ack_e}, {31'h0, x_ack_e});
        chk("stl_e", {31'h0, stl_e}, {31'h0, x_stl_e});
        if (dtr_e_known) chk("dtr_e", dtr_e, x_dtr_e);
        if (auto_mem && stb_m) mem_left = int'($urandom_range(0, 3));
    endtask

    initial begin
        reset = 1'b0; stb_f = 1'b0; flush_f = 1'b0; stb_e = 1'b0; rw_e = 1'b0; ack_m = 1'b0;
        addr_f = 32'h0; addr_e = 32'h0; dtw_e = 32'h0; dtr_m = 32'h0;
        cycle(); cycle();
        reset = 1'b1;
        cycle();

        // Fetch read, memory acks 3 cycles after stb_m
        addr_f = 32'h100; stb_f = 1'b1; cycle(); stb_f = 1'b0;
        chk("t1_stb_m", {31'h0, stb_m}, 32'h1);
        chk("t1_addr_m", addr_m, 32'h100);
        cycle(); cycle();
        ack_m = 1'b1; dtr_m = 32'hDEADBEEF; cycle(); ack_m = 1'b0;
        chk("t1_ack_f", {31'h0, ack_f}, 32'h1);
        chk("t1_dtr_f", dtr_f, 32'hDEADBEEF);
        cycle();

        // Collision: execute wins, fetch stalls and re-strobes
        addr_f = 32'h200; stb_f = 1'b1;
        addr_e = 32'h300; dtw_e = 32'h12345678; rw_e = 1'b1; stb_e = 1'b1;
        cycle(); stb_f = 1'b0; stb_e = 1'b0;
        chk("t2_stl_f", {31'h0, stl_f}, 32'h1);
        chk("t2_addr_m", addr_m, 32'h300);
        chk("t2_dtw_m", dtw_m, 32'h12345678);
        chk("t2_rw_m", {31'h0, rw_m}, 32'h1);
        cycle();
        ack_m = 1'b1; dtr_m = $urandom; cycle(); ack_m = 1'b0;
        chk("t2_ack_e", {31'h0, ack_e}, 32'h1);
        stb_f = 1'b1; cycle(); stb_f = 1'b0;
        chk("t2_refetch_addr", addr_m, 32'h200);
        ack_m = 1'b1; dtr_m = $urandom; cycle(); ack_m = 1'b0;
        cycle();

        // Execute refused while fetch outstanding
        addr_f = {$urandom_range(0, 255), 2'b00}; stb_f = 1'b1; cycle(); stb_f = 1'b0;
        addr_e = $urandom; rw_e = 1'b0; stb_e = 1'b1; cycle(); stb_e = 1'b0;
        chk("t3_stl_e", {31'h0, stl_e}, 32'h1);
        held_dtr_f = $urandom;
        ack_m = 1'b1; dtr_m = held_dtr_f; cycle(); ack_m = 1'b0;
        chk("t3_dtr_f", dtr_f, held_dtr_f);
        cycle();

        // Flush discards the outstanding fetch
        addr_f = 32'h400; stb_f = 1'b1; cycle(); stb_f = 1'b0;
        flush_f = 1'b1; cycle(); flush_f = 1'b0;
        addr_f = 32'h800; stb_f = 1'b1; cycle(); stb_f = 1'b0;
        chk("t4_stl_f", {31'h0, stl_f}, 32'h1);
        ack_m = 1'b1; dtr_m = 32'hCAFEF00D; cycle(); ack_m = 1'b0;
        chk("t4_no_ack_f", {31'h0, ack_f}, 32'h0);
        chk("t4_dtr_f_held", dtr_f, held_dtr_f);
        stb_f = 1'b1; cycle(); stb_f = 1'b0;
        chk("t4_addr_m", addr_m, 32'h800);
        ack_m = 1'b1; dtr_m = $urandom; cycle(); ack_m = 1'b0;
        chk("t4_ack_f", {31'h0, ack_f}, 32'h1);

        // Back-to-back prefetch of four words, strobe right after each ack
        for (int i = 0; i < 4; i++) begin
            words[i] = $urandom;
            addr_f = 32'(i * 4); stb_f = 1'b1; cycle(); stb_f = 1'b0;
            chk("t5_stl_f", {31'h0, stl_f}, 32'h0);
            chk("t5_addr_m", addr_m, 32'(i * 4));
            ack_m = 1'b1; dtr_m = words[i]; cycle(); ack_m = 1'b0;
            chk("t5_dtr_f", dtr_f, words[i]);
        end
        cycle();

        // Reset during an execute transaction, late ack ignored
        addr_e = $urandom; rw_e = 1'b0; stb_e = 1'b1; cycle(); stb_e = 1'b0;
        cycle();
        reset = 1'b0; cycle(); reset = 1'b1;
        ack_m = 1'b1; dtr_m = $urandom; cycle(); ack_m = 1'b0;
        chk("t6_no_ack_e", {31'h0, ack_e}, 32'h0);
        chk("t6_addr_m", addr_m, 32'h0);
        addr_e = 32'h0000_1230; stb_e = 1'b1; cycle(); stb_e = 1'b0;
        chk("t6_addr_m_new", addr_m, 32'h0000_1230);
        ack_m = 1'b1; dtr_m = $urandom; cycle(); ack_m = 1'b0;
        chk("t6_ack_e", {31'h0, ack_e}, 32'h1);
        cycle();

        // Randomized traffic with random memory latency, flushes and resets
        auto_mem = 1'b1;
        for (int n = 0; n < 400; n++) begin
            stb_f   = (owner != 1) && (($urandom % 3) == 0);
            addr_f  = $urandom;
            flush_f = (($urandom % 8) == 0);
            stb_e   = (owner != 2) && (($urandom % 3) == 0);
            addr_e  = $urandom;
            dtw_e   = $urandom;
            rw_e    = $urandom_range(0, 1) == 1;
            reset   = (($urandom % 60) != 0);
            cycle();
        end
        stb_f = 1'b0; stb_e = 1'b0; flush_f = 1'b0; reset = 1'b1;
        cycle(); cycle(); cycle(); cycle(); cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hs32_mem_arbiter.md
Name: hs32_mem_arbiter

Overview:
Single-bus memory arbiter that sits directly upstream of hs32_fetch and feeds its memory interface (addr/dtr/stbm/ackm/stlm). It shares one memory port between the fetch stage (read-only) and the execute stage (load/store). It accepts one-cycle strobes, runs one transaction at a time, and returns the read data with ack or refuses the request with a one-cycle stall pulse, after which the client re-strobes. It also swallows in-flight fetch data when the pipeline flushes.

Parameters:
EXEC_PRIORITY, 1, 1 = execute wins simultaneous strobes in IDLE, 0 = fetch wins

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
addr_f  in  32  fetch address, valid with stb_f
stb_f  in  1  fetch request pulse
dtr_f  out  32  fetch read data, valid with ack_f
ack_f  out  1  fetch data valid pulse
stl_f  out  1  fetch request refused pulse
flush_f  in  1  pipeline flush; discards outstanding fetch
addr_e  in  32  execute address
dtw_e  in  32  execute write data
rw_e  in  1  1 = write, 0 = read
stb_e  in  1  execute request pulse
dtr_e  out  32  execute read data
ack_e  out  1  execute done pulse (reads and writes)
stl_e  out  1  execute request refused pulse
addr_m  out  32  memory address
dtw_m  out  32  memory write data
rw_m  out  1  memory direction
stb_m  out  1  memory request pulse
dtr_m  in  32  memory read data, valid with ack_m
ack_m  in  1  memory done pulse

Behaviour:
- All outputs are registered. Reset (reset==0 at a clk edge) sets state to IDLE, clears drop, and drives every output to 0. Reset mid-transaction abandons the transaction. An ack_m that arrives later is ignored because the arbiter is in IDLE.
- States:
  - IDLE
  - BUSY_F: fetch transaction outstanding
  - BUSY_E: execute transaction outstanding
- IDLE, stb sampled at edge t:
  - The winner's addr/dtw/rw are latched into addr_m/dtw_m/rw_m.
  - stb_m=1 during cycle t+1 only.
  - State goes to BUSY_F or BUSY_E.
  - Fetch requests always drive rw_m=0 and dtw_m=0.
- Simultaneous stb_f and stb_e in IDLE: EXEC_PRIORITY picks the winner. The loser gets stl_x=1 for exactly one cycle (t+1).
- Any stb_x sampled while the state is not IDLE gives stl_x=1 in the next cycle. The state is unaffected.
- stb_f sampled together with flush_f is ignored: no stl_f and no transaction.
- addr_m/dtw_m/rw_m stay stable from stb_m until ack_m is sampled.
- ack_m sampled at edge k in BUSY_x:
  - ack_x=1 and dtr_x=dtr_m during cycle k+1 (one-cycle pulse).
  - State returns to IDLE at edge k.
  - A strobe sampled at edge k+1 is accepted, so back-to-back transactions are possible.
  - Minimum strobe-to-ack latency seen by a client is 2 cycles plus the memory latency.
- dtr_x holds its last value when ack_x=0. dtr_e is updated on writes too, with don't-care data.
- Flush:
  - flush_f sampled in BUSY_F sets drop. When ack_m completes, state goes to IDLE, ack_f stays 0, dtr_f is unchanged, and drop is cleared.
  - flush_f in IDLE or BUSY_E has no effect. An execute transaction is never dropped.
- ack_m sampled in IDLE is ignored.
- stl_x and ack_x are never both 1 in the same cycle for the same client.
- At most one outstanding memory transaction. No queueing: a refused client must re-strobe.

Decomposition:
- Shared package hs32_pkg:
  - State encoding ARB_IDLE/ARB_BUSY_F/ARB_BUSY_E (2 bits).
  - Constants for rw encoding (RW_READ=0, RW_WRITE=1).
- No sub-module: a single flat module. Grant selection is a small combinational function inside it.

Test Plan:
- Fetch read: stb_f with addr_f=0x100; memory acks 3 cycles after stb_m with dtr_m=0xDEADBEEF -> stb_m one cycle with addr_m=0x100, rw_m=0; ack_f=1 with dtr_f=0xDEADBEEF the cycle after ack_m; stl_f never asserted.
- Collision, EXEC_PRIORITY=1: stb_f (0x200) and stb_e (write 0x300, dtw_e=0x12345678) in the same cycle -> stl_f pulse; stb_m with addr_m=0x300, rw_m=1, dtw_m=0x12345678; ack_e after ack_m. Fetch re-strobe is then served with addr_m=0x200.
- Busy refusal: stb_e issued while in BUSY_F -> stl_e pulse the next cycle; fetch transaction completes normally.
- Flush: stb_f at 0x400, flush_f during BUSY_F, ack_m with 0xCAFEF00D -> ack_f stays 0 and dtr_f is unchanged. A new stb_f at 0x800 refused while busy, then re-strobed, completes with addr_m=0x800.
- Back-to-back: client re-strobes in the first cycle after ack_x (fetch prefetch loop filling 4 words at 0x0,0x4,0x8,0xC) -> four transactions, no stl_f, ack_f data in order.
- Reset: reset=0 during BUSY_E, then ack_m arrives -> all outputs 0, no ack_e; the next stb_e is accepted normally.
